alu_core: RTL and testbench
===========================

Name: alu_core

Overview:
- Start/done-handshaked arithmetic-logic unit.
- Operands and opcode are captured on a start pulse. A registered result is returned with a one-cycle done pulse.
- Single-cycle logic/add ops plus a multi-cycle multiply.
- Sits behind a bus-functional interface that drives operands and samples result/done.

Parameters:
- WIDTH, 8, operand width; result is 2*WIDTH bits.
- MUL_LATENCY, 3, cycles from start sample to done for MUL (minimum 2).

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- A  in  WIDTH  operand A, unsigned
- B  in  WIDTH  operand B, unsigned
- op  in  3  opcode
- start  in  1  operation request, sampled on rising clk
- result  out  2*WIDTH  registered result
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset (reset_n low, asynchronous): result=0, done=0, FSM=IDLE, captured operands=0, counter=0. Deassertion is taken synchronously by design.
- Opcodes, with operands zero-extended to 2*WIDTH:
  - 0 NOP: result holds its previous value.
  - 1 ADD: A+B.
  - 2 SUB: A-B, wrap mod 2^(2*WIDTH).
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 MUL: A*B.
  - 7 SHL: A shifted left by B[3:0].
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - start=1 captures A, B, op.
  - op!=6: go to DONE. On that edge, result gets the computed value and done=1 in the following cycle. Latency is 1 cycle.
  - op==6: go to BUSY, counter loaded with MUL_LATENCY-1.
- BUSY: counter decrements each cycle. At 1, result gets A*B and done=1 next cycle. Total start-to-done latency = MUL_LATENCY cycles.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- start seen while in DONE is ignored. A new request needs start high in IDLE.
- Back-to-back ops are therefore at most one every 2 cycles.
- start while BUSY: ignored; inputs are not recaptured.
- Changes to A/B/op after capture have no effect on the op in flight.
- result holds until the next completing op. done deasserts after its single cycle.
- start held high continuously: a new op is accepted every time the FSM is in IDLE.
- Reset mid-operation (any state): immediate return to reset values; no done pulse is produced for the aborted op.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: MUL as above (multi-cycle, BUSY state used).
- Undefined: multiplier logic omitted. op 6 behaves as single-cycle, result=0, done one cycle after start. BUSY state is unreachable.

Decomposition:
- Package alu_pkg: opcode enum (OP_NOP..OP_SHL, 3-bit), FSM state enum, default WIDTH/MUL_LATENCY constants.
- One natural sub-module, alu_datapath: purely combinational op decode producing the 2*WIDTH value from captured A/B/op.
- FSM, counter and output registers remain in alu_core.

Test Plan:
- Reset: hold reset_n=0 for 1 cycle -> result=0, done=0. Assert reset_n=0 mid-MUL -> outputs 0 immediately, no done pulse.
- ADD: A=8'hFF, B=8'h01, op=1, start 1 cycle -> done pulses 1 cycle later, result=16'h0100.
- SUB wrap: A=8'h03, B=8'h05, op=2 -> result=16'hFFFE. AND/OR/XOR with A=8'hF0, B=8'h3C -> 16'h0030 / 16'h00FC / 16'h00CC.
- MUL: A=8'hFF, B=8'hFF, op=6 -> done exactly 3 cycles after start sample, result=16'hFE01. start pulsed during BUSY is ignored.
- Back-to-back: ADD 2+3 then immediately MUL 4*5 with start held high -> results 5 then 20, done pulses separated per latency rules. NOP afterwards -> done pulses, result stays 20.
- Build without ALU_MUL_EN: op=6, A=3, B=4 -> done after 1 cycle, result=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode/state definitions and default sizing for the alu_core block.
// Build option ALU_MUL_EN (see alu_core) does not change anything in this package.
package alu_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_MUL_LATENCY = 3;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_MUL = 3'd6,
        OP_SHL = 3'd7
    } op_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_datapath.sv
// Combinational op decode: zero-extends the operands and produces the 2*WIDTH value.
// The multiplier exists only when ALU_MUL_EN is defined; otherwise OP_MUL yields 0.
module alu_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2:0]         op,
    output logic [2*WIDTH-1:0] y
);

    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;

    assign a_ext = {{WIDTH{1'b0}}, a};
    assign b_ext = {{WIDTH{1'b0}}, b};

    always_comb begin
        y = '0;
        case (op_e'(op))
            OP_ADD:  y = a_ext + b_ext;
            OP_SUB:  y = a_ext - b_ext;
            OP_AND:  y = a_ext & b_ext;
            OP_OR:   y = a_ext | b_ext;
            OP_XOR:  y = a_ext ^ b_ext;
`ifdef ALU_MUL_EN
            OP_MUL:  y = a_ext * b_ext;
`endif
            OP_SHL:  y = a_ext << b[3:0];
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_core.sv
// Start/done handshaked ALU: IDLE -> (BUSY for MUL) -> DONE, registered result and done pulse.
// Define ALU_MUL_EN to build the multi-cycle multiplier; without it MUL completes in one cycle with 0.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int MUL_LATENCY = DEF_MUL_LATENCY
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [2:0]         op,
    input  logic               start,
    output logic [2*WIDTH-1:0] result,
    output logic               done
);

    localparam int CNT_W = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   dp_a, dp_b;
    logic [2:0]         dp_op;
    logic [2*WIDTH-1:0] dp_y;
    logic               go_busy;

    // Single-cycle ops complete on the capture edge, so the datapath sees live inputs in IDLE
    assign dp_a  = (state_q == ST_BUSY) ? a_q  : A;
    assign dp_b  = (state_q == ST_BUSY) ? b_q  : B;
    assign dp_op = (state_q == ST_BUSY) ? op_q : op;

    alu_datapath #(.WIDTH(WIDTH)) u_datapath (
        .a  (dp_a),
        .b  (dp_b),
        .op (dp_op),
        .y  (dp_y)
    );

    always_comb begin
`ifdef ALU_MUL_EN
        go_busy = (op == OP_MUL);
`else
        go_busy = 1'b0;
`endif
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d  = A;
                    b_d  = B;
                    op_d = op;
                    if (go_busy) begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_W'(MUL_LATENCY - 1);
                    end else begin
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                        result_d = (op == OP_NOP) ? result_q : dp_y;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = ST_DONE;
                    done_d   = 1'b1;
                    result_d = dp_y;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed cases plus randomized ops against an arithmetic model.
// Expectations follow ALU_MUL_EN the same way the design build does.
module tb_alu_core;

    localparam int W       = 8;
    localparam int MUL_LAT = 3;

`ifdef ALU_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset_n;
    logic [W-1:0]   A, B;
    logic [2:0]     op;
    logic           start;
    logic [2*W-1:0] result;
    logic           done;

    int n_checks = 0;
    int n_pass   = 0;
    logic [2*W-1:0] model_res = '0;

    alu_core #(.WIDTH(W), .MUL_LATENCY(MUL_LAT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .A       (A),
        .B       (B),
        .op      (op),
        .start   (start),
        .result  (result),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [2*W-1:0] model(input int a, input int b, input int o,
                                             input logic [2*W-1:0] prev);
        int r;
        case (o)
            0: r = int'(prev);
            1: r = a + b;
            2: r = (a - b + 65536) % 65536;
            3: r = a & b;
            4: r = a | b;
            5: r = a ^ b;
            6: r = MUL_ON ? a * b : 0;
            default: r = (a * (1 << (b % 16))) % 65536;
        endcase
        return r[2*W-1:0];
    endfunction

    function automatic int model_lat(input int o);
        return (o == 6 && MUL_ON) ? MUL_LAT : 1;
    endfunction

    // Called on a falling edge with the DUT idle; returns on a falling edge with the DUT idle.
    task automatic do_op(input int a, input int b, input int o, input string tag);
        logic [2*W-1:0] exp;
        int exp_lat, lat;
        bit seen;
        exp     = model(a, b, o, model_res);
        exp_lat = model_lat(o);
        A = a[W-1:0]; B = b[W-1:0]; op = o[2:0]; start = 1'b1;
        lat = 0; seen = 0;
        while (!seen && lat < 10) begin
            @(negedge clk);
            lat++;
            start = (lat == 1 && exp_lat > 2);
            A = W'($urandom); B = W'($urandom); op = 3'($urandom);
            seen = done;
        end
        check({tag, "_lat"}, seen ? lat : -1, exp_lat);
        check({tag, "_res"}, result, exp);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_pulse"}, done, 1'b0);
        check({tag, "_hold"}, result, exp);
        model_res = exp;
    endtask

    initial begin
        int lat, exp_lat, dones;
        reset_n = 1'b0; start = 1'b0; A = '0; B = '0; op = '0;
        @(negedge clk);
        check("rst_result", result, 0);
        check("rst_done", done, 0);
        reset_n = 1'b1;
        @(negedge clk);

        do_op(8'hFF, 8'h01, 1, "add");
        do_op(8'h03, 8'h05, 2, "sub_wrap");
        do_op(8'hF0, 8'h3C, 3, "and");
        do_op(8'hF0, 8'h3C, 4, "or");
        do_op(8'hF0, 8'h3C, 5, "xor");
        do_op(8'hFF, 8'hFF, 6, "mul");
        do_op(8'h03, 8'h04, 6, "mul_small");
        do_op(8'h81, 8'h0F, 7, "shl");
        do_op(8'h12, 8'h34, 0, "nop");

        // Back-to-back with start held high: ADD 2+3 then MUL 4*5
        A = 2; B = 3; op = 3'd1; start = 1'b1;
        @(negedge clk);
        check("b2b_add_done", done, 1'b1);
        check("b2b_add_res", result, 16'd5);
        A = 4; B = 5; op = 3'd6;
        @(negedge clk);
        check("b2b_gap", done, 1'b0);
        exp_lat = model_lat(6);
        lat = 0;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("b2b_mul_lat", lat, exp_lat);
        check("b2b_mul_res", result, MUL_ON ? 16'd20 : 16'd0);
        model_res = MUL_ON ? 16'd20 : 16'd0;
        @(negedge clk);
        check("b2b_mul_pulse", done, 1'b0);
        do_op(8'h77, 8'h11, 0, "b2b_nop");

        // Reset in the middle of an operation
        do_op(1, 1, 1, "pre_rst");
        A = 8'h0F; B = 8'h0F; op = 3'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("midrst_result", result, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midrst_no_done", dones, 0);
        model_res = '0;

        for (int i = 0; i < 40; i++) begin
            do_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 7)), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
